// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, class flag bit positions
// and the class type used by the result queue.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  // Bit positions inside an fp_class_t word ({nan, inf, denorm, zero}).
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_DENORM = 1;
  localparam int FLAG_INF    = 2;
  localparam int FLAG_NAN    = 3;

  typedef logic [3:0] fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier: maps an FP word to a one-hot (or all-zero)
// class vector {nan, inf, denorm, zero}. The sign bit does not affect class.
module fp_classify
  import fp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  output fp_class_t        cls
);

  logic [EXP_W-1:0]               exp_s;
  logic [FRAC_W-1:0]              frac_s;
  logic [WIDTH-EXP_W-FRAC_W-1:0]  sign_unused_s;

  assign exp_s         = word[FRAC_W +: EXP_W];
  assign frac_s        = word[FRAC_W-1:0];
  assign sign_unused_s = word[WIDTH-1:EXP_W+FRAC_W];

  // Decode exponent/fraction extremes into at most one class flag.
  always_comb begin
    cls = 4'b0000;
    if (exp_s == EXP_MAX) begin
      if (frac_s != {FRAC_W{1'b0}}) begin
        cls[FLAG_NAN] = 1'b1;
      end else begin
        cls[FLAG_INF] = 1'b1;
      end
    end else if (exp_s == {EXP_W{1'b0}}) begin
      if (frac_s != {FRAC_W{1'b0}}) begin
        cls[FLAG_DENORM] = 1'b1;
      end else begin
        cls[FLAG_ZERO] = 1'b1;
      end
    end else begin
      cls = 4'b0000;
    end
  end

endmodule

// File: rtl/fp_result_queue.sv
// First-word-fall-through queue of FP results. Each entry carries the result
// word, its operation tag and a class vector computed when it is pushed.
// Sticky bits remember whether any NaN or Inf has been pushed.
module fp_result_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_op,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 sticky,
  input  logic                       clr_sticky
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + 1 + 4;

  // Entry layout: {op, class[3:0], result[WIDTH-1:0]}.
  logic [ENTRY_W-1:0] mem_r [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [1:0]       sticky_r;

  fp_class_t        push_cls_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [1:0]       sticky_nxt_s;
  logic [ENTRY_W-1:0] head_s;

  fp_classify #(.WIDTH(WIDTH)) u_classify (
    .word (in_result),
    .cls  (push_cls_s)
  );

  // Handshakes use the registered ready/valid, so a full queue never
  // accepts a push even when the head is popped in the same cycle.
  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Next occupancy and next sticky state; set beats clear.
  always_comb begin
    count_nxt_s  = count_r;
    sticky_nxt_s = sticky_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    if (clr_sticky) begin
      sticky_nxt_s = 2'b00;
    end else begin
      sticky_nxt_s = sticky_r;
    end
    if (push_s) begin
      sticky_nxt_s = sticky_nxt_s | {push_cls_s[FLAG_NAN], push_cls_s[FLAG_INF]};
    end else begin
      sticky_nxt_s = sticky_nxt_s;
    end
  end

  // Control state: pointers, occupancy, registered ready/valid and sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sticky_r    <= 2'b00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != CNT_W'(DEPTH));
      out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      sticky_r    <= sticky_nxt_s;
    end
  end

  // Entry storage; contents are not cleared by reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {in_op, push_cls_s, in_result};
    end
  end

  assign head_s     = mem_r[rd_ptr_r];
  assign out_result = head_s[WIDTH-1:0];
  assign out_flags  = head_s[WIDTH+3:WIDTH];
  assign out_op     = head_s[WIDTH+4];

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign sticky    = sticky_r;

endmodule
